// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: pops words into a
// 2-entry skid buffer and presents them as a valid/ready stream.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             rd_empty,
  input  logic [DSIZE-1:0] rd_data,
  output logic             rd_inc,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] pop_cnt
);

  logic [DSIZE-1:0] mem [2];
  logic             head;
  logic             tail;
  logic             xfer;

  // Refill depends only on registered occ, never on out_ready.
  assign rd_inc    = !rd_rst && !rd_empty && (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign xfer      = out_valid && out_ready;
  assign out_data  = mem[head];

  // Buffer storage, pointers, occupancy and pop counter.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      occ     <= 2'd0;
      pop_cnt <= '0;
    end else begin
      if (rd_inc) begin
        mem[tail] <= rd_data;
        tail      <= ~tail;
        pop_cnt   <= pop_cnt + 1'b1;
      end
      if (xfer) begin
        head <= ~head;
      end
      occ <= occ + {1'b0, rd_inc} - {1'b0, xfer};
    end
  end

  // Occupancy of 3 would mean the pop gate failed.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      assert (occ != 2'd3);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed table, streaming/wrap
// sequence and randomized traffic against a queue model.
module tb_fifo_rd_stream;

  logic        rd_clk;
  logic        rd_rst;
  logic        rd_empty;
  logic [7:0]  rd_data;
  logic        rd_inc;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  occ;
  logic [15:0] pop_cnt;

  logic        rd_inc4;
  logic [7:0]  out_data4;
  logic        out_valid4;
  logic [1:0]  occ4;
  logic [3:0]  pop_cnt4;

  fifo_rd_stream #(.DSIZE(8), .CNT_W(16)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_empty(rd_empty),
    .rd_data(rd_data), .rd_inc(rd_inc), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .occ(occ),
    .pop_cnt(pop_cnt)
  );

  fifo_rd_stream #(.DSIZE(8), .CNT_W(4)) dut4 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_empty(rd_empty),
    .rd_data(rd_data), .rd_inc(rd_inc4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .occ(occ4),
    .pop_cnt(pop_cnt4)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  typedef struct {
    bit         rst;
    bit         rdy;
    int         push_n;
    logic [7:0] base;
    bit         e_inc;
    bit         e_val;
    logic [1:0] e_occ;
    bit         chk_dat;
    logic [7:0] e_dat;
    int         e_cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  ref_q[$];
  int unsigned cnt;
  int          n_tests;
  int          n_fail;

  logic        s_inc;
  logic        s_val;
  logic [7:0]  s_dat;
  logic [1:0]  s_occ;
  logic [15:0] s_cnt;
  logic [3:0]  s_cnt4;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) fifo_q.push_back(base + 8'(k));
  endtask

  // One clock: drive, compare with model at negedge, advance model.
  task automatic cycle(input bit rst, input bit rdy, input bit chk);
    bit e_inc;
    bit e_val;
    int e_occ;
    rd_rst    = rst;
    out_ready = rdy;
    rd_empty  = (fifo_q.size() == 0);
    rd_data   = rd_empty ? 8'($urandom) : fifo_q[0];
    e_inc = !rst && !rd_empty && (ref_q.size() != 2);
    e_val = (ref_q.size() != 0);
    e_occ = ref_q.size();
    @(negedge rd_clk);
    s_inc  = rd_inc;
    s_val  = out_valid;
    s_dat  = out_data;
    s_occ  = occ;
    s_cnt  = pop_cnt;
    s_cnt4 = pop_cnt4;
    if (chk) begin
      check("m_rd_inc", 32'(rd_inc), 32'(e_inc));
      check("m_valid", 32'(out_valid), 32'(e_val));
      check("m_occ", 32'(occ), 32'(e_occ));
      if (e_val) check("m_data", 32'(out_data), 32'(ref_q[0]));
      check("m_cnt", 32'(pop_cnt), cnt & 32'hFFFF);
      check("m_cnt4", 32'(pop_cnt4), cnt & 32'hF);
      check("m_inc4", 32'(rd_inc4), 32'(e_inc));
    end
    @(posedge rd_clk);
    if (rst) begin
      ref_q.delete();
      fifo_q.delete();
      cnt = 0;
    end else begin
      if (e_val && rdy) void'(ref_q.pop_front());
      if (e_inc) begin
        ref_q.push_back(fifo_q.pop_front());
        cnt++;
      end
    end
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cnt       = 0;
    rd_rst    = 1'b1;
    rd_empty  = 1'b1;
    rd_data   = 8'h00;
    out_ready = 1'b0;

    // rst rdy n base  inc val occ cd dat cnt
    tbl.push_back('{1, 1, 1, 8'h11, 0, 0, 2'd0, 1, 8'h00, 0});
    tbl.push_back('{1, 1, 1, 8'h11, 0, 0, 2'd0, 1, 8'h00, 0});
    tbl.push_back('{1, 1, 1, 8'h11, 0, 0, 2'd0, 1, 8'h00, 0});
    tbl.push_back('{0, 1, 1, 8'hA5, 1, 0, 2'd0, 0, 8'h00, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 0, 1, 2'd1, 1, 8'hA5, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 0, 0, 2'd0, 0, 8'h00, 1});
    tbl.push_back('{0, 0, 4, 8'hB0, 1, 0, 2'd0, 0, 8'h00, 1});
    tbl.push_back('{0, 0, 0, 8'h00, 1, 1, 2'd1, 1, 8'hB0, 2});
    tbl.push_back('{0, 0, 0, 8'h00, 0, 1, 2'd2, 1, 8'hB0, 3});
    tbl.push_back('{0, 0, 0, 8'h00, 0, 1, 2'd2, 1, 8'hB0, 3});
    tbl.push_back('{0, 1, 0, 8'h00, 0, 1, 2'd2, 1, 8'hB0, 3});
    tbl.push_back('{0, 1, 0, 8'h00, 1, 1, 2'd1, 1, 8'hB1, 3});
    tbl.push_back('{0, 1, 0, 8'h00, 1, 1, 2'd1, 1, 8'hB2, 4});
    tbl.push_back('{0, 1, 0, 8'h00, 0, 1, 2'd1, 1, 8'hB3, 5});
    tbl.push_back('{0, 1, 0, 8'h00, 0, 0, 2'd0, 0, 8'h00, 5});
    tbl.push_back('{0, 0, 3, 8'hC0, 1, 0, 2'd0, 0, 8'h00, 5});
    tbl.push_back('{0, 0, 0, 8'h00, 1, 1, 2'd1, 1, 8'hC0, 6});
    tbl.push_back('{0, 0, 0, 8'h00, 0, 1, 2'd2, 1, 8'hC0, 7});
    tbl.push_back('{1, 1, 0, 8'h00, 0, 1, 2'd2, 1, 8'hC0, 7});
    tbl.push_back('{0, 1, 1, 8'hD0, 1, 0, 2'd0, 1, 8'h00, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 0, 1, 2'd1, 1, 8'hD0, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 0, 0, 2'd0, 0, 8'h00, 1});

    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      push_words(tbl[i].push_n, tbl[i].base);
      cycle(tbl[i].rst, tbl[i].rdy, 1'b1);
      check($sformatf("t%0d_inc", i), 32'(s_inc), 32'(tbl[i].e_inc));
      check($sformatf("t%0d_val", i), 32'(s_val), 32'(tbl[i].e_val));
      check($sformatf("t%0d_occ", i), 32'(s_occ), 32'(tbl[i].e_occ));
      check($sformatf("t%0d_cnt", i), 32'(s_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].chk_dat)
        check($sformatf("t%0d_dat", i), 32'(s_dat), 32'(tbl[i].e_dat));
    end

    // Streaming 17 words back to back, also wrapping the 4-bit counter.
    cycle(1'b1, 1'b1, 1'b1);
    push_words(17, 8'h00);
    for (int i = 0; i <= 18; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      if (i >= 1 && i <= 17) begin
        check($sformatf("s%0d_val", i), 32'(s_val), 32'd1);
        check($sformatf("s%0d_dat", i), 32'(s_dat), 32'(i - 1));
      end
      if (i == 0 || i == 18) check($sformatf("s%0d_val", i), 32'(s_val), 32'd0);
      if (i == 16) check("s_cnt16", 32'(s_cnt), 32'd16);
      if (i == 15) check("w_cnt15", 32'(s_cnt4), 32'hF);
      if (i == 16) check("w_cnt16", 32'(s_cnt4), 32'h0);
      if (i == 17) check("w_cnt17", 32'(s_cnt4), 32'h1);
    end

    // Randomized traffic with bursty ready and rare resets.
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      bit rst;
      if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0)
        push_words(int'($urandom_range(0, 2)), 8'($urandom));
      if ((i / 64) % 2 == 0) rdy = ($urandom_range(0, 3) != 0);
      else rdy = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cycle(rst, rdy, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer of the asynchronous FIFO, living entirely in the rd_clk domain.
- Drains the FIFO through its rd_empty / rd_inc / rd_data read port and re-presents the words as a registered valid/ready stream.
- A 2-entry skid buffer decouples downstream backpressure from the FIFO pop, so full throughput (one word per cycle) is sustained.
- Also provides buffer occupancy and a wrapping pop counter for debug and verification.

Parameters:
- DSIZE, 8, data word width; must match the FIFO DSIZE.
- CNT_W, 16, width of the pop counter.

Ports:
- rd_clk, input, 1, read-domain clock; all logic is on its rising edge.
- rd_rst, input, 1, synchronous active-high reset.
- rd_empty, input, 1, FIFO empty flag (rd_clk domain).
- rd_data, input, DSIZE, FIFO read data; valid in the same cycle that rd_empty is low.
- rd_inc, output, 1, FIFO pop; the read pointer advances at the next rd_clk edge.
- out_data, output, DSIZE, stream data, driven from the buffer head register.
- out_valid, output, 1, stream valid.
- out_ready, input, 1, downstream ready.
- occ, output, 2, buffer occupancy (0..2).
- pop_cnt, output, CNT_W, count of FIFO pops since reset.

Behaviour:
- Clocking and reset:
  - One clock (rd_clk).
  - Reset is synchronous and active-high (rd_rst), sampled on the rd_clk rising edge.
  - While rd_rst is high, rd_inc = 0 combinationally.
  - On rd_rst: occ = 0, out_valid = 0, out_data = 0, pop_cnt = 0, head/tail pointers = 0.
- Reset mid-operation: any buffered words are discarded, with no output or pop the following cycle. The FIFO pointers are reset by the same rd_rst, so no word is duplicated.
- Pop rule (combinational): rd_inc = !rd_rst && !rd_empty && (occ != 2). The FIFO is never popped when the buffer is full.
- Stream handshake:
  - out_valid = (occ != 0).
  - A transfer occurs in a cycle where out_valid && out_ready.
  - out_data = buffer[head]; it must stay stable while out_valid && !out_ready.
- Buffer writes: on rd_inc, rd_data is written to buffer[tail] and tail toggles.
- Buffer reads: on a transfer, head toggles.
- Occupancy update, next occ = occ + rd_inc - transfer:
  - Pop and transfer in the same cycle leaves occ unchanged.
  - At occ = 1 with both events, the new word lands in the free slot.
- Buffer full (occ = 2): rd_inc = 0.
  - A transfer at occ = 2 drops occ to 1.
  - The FIFO is popped again on the following cycle. Refill is not combinational on out_ready, to keep the rd_inc timing path short.
- Buffer empty (occ = 0): a word popped in cycle N appears with out_valid = 1 in cycle N+1. Latency from FIFO to stream is 1 cycle.
- Throughput: at steady state with occ = 1, out_ready = 1 and the FIFO non-empty, there is one pop and one transfer every cycle.
- Ordering: strict FIFO order; no word is lost or duplicated.
- pop_cnt:
  - Increments by 1 on every rd_inc cycle.
  - Wraps modulo 2^CNT_W, so all-ones + 1 = 0.
  - Unaffected by out_ready.
- Head/tail: 1-bit pointers that wrap 1 -> 0.
- occ = 3 is unreachable; the implementation asserts against it in simulation.

Test Plan:
- Reset hold: rd_rst = 1 and rd_empty = 0 for 3 cycles -> rd_inc = 0, out_valid = 0, occ = 0, pop_cnt = 0 throughout.
- Single word: FIFO holds 0xA5, out_ready = 1 -> rd_inc = 1 in cycle 0; out_valid = 1 with out_data = 0xA5 in cycle 1; occ returns to 0 in cycle 2; pop_cnt = 1.
- Streaming: 16 words 0x00..0x0F, out_ready = 1 -> after 1 cycle of latency, 16 consecutive transfers in order with no bubbles; pop_cnt = 16.
- Backpressure:
  - With 4 words queued and out_ready = 0 -> exactly 2 pops, occ = 2, rd_inc = 0 thereafter.
  - out_data holds the first word stable.
  - On releasing out_ready -> remaining words delivered in order, total 4.
- Reset mid-stream: rd_rst asserted with occ = 2 -> next cycle occ = 0, out_valid = 0, no transfer; after release, normal operation resumes on new data.
- Counter wrap: CNT_W = 4, 17 pops -> pop_cnt reads 0xF after 15 pops, 0x0 after 16, 0x1 after 17.
